// File: rtl/pattern_row_serializer_m_if.sv
// Row handshake between the pattern fetch/flip stage and the serializer.
// The master offers a pattern row plus its palette select; the slave accepts on valid & ready.
interface pattern_row_serializer_m_if #(
    parameter int ROW_W  = 16,
    parameter int ATTR_W = 3
);
    logic [ROW_W-1:0]  row_in;
    logic [ATTR_W-1:0] row_attr;
    logic              row_valid;
    logic              row_ready;

    modport master (
        output row_in,
        output row_attr,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_in,
        input  row_attr,
        input  row_valid,
        output row_ready
    );
endinterface

// File: rtl/pattern_row_serializer_m.sv
// Pattern row serializer: shifts 2bpp pattern rows out one pixel per pixel_en, leftmost first.
// An active shift register plus one pending row buffer lets the next row be fetched while the
// current one shifts, so pixels stay gap-free across row boundaries.
module pattern_row_serializer_m #(
    parameter int PIXEL_BITS     = 2,
    parameter int PIXELS_PER_ROW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pattern_row_serializer_m_if.slave up,
    input  logic                  flush,
    input  logic                  pixel_en,
    output logic [PIXEL_BITS-1:0] pixel_out,
    output logic [2:0]            pixel_attr,
    output logic                  pixel_valid,
    output logic                  pixel_last,
    output logic                  underrun
);
    localparam int ROW_W = PIXEL_BITS * PIXELS_PER_ROW;
    localparam int CNT_W = $clog2(PIXELS_PER_ROW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXELS_PER_ROW - 1);

    logic [ROW_W-1:0] act_row,   act_row_n;
    logic [2:0]       act_attr,  act_attr_n;
    logic [CNT_W-1:0] act_cnt,   act_cnt_n;
    logic             act_full,  act_full_n;
    logic [ROW_W-1:0] pend_row,  pend_row_n;
    logic [2:0]       pend_attr, pend_attr_n;
    logic             pend_full, pend_full_n;
    logic             underrun_q, underrun_n;

    logic accept;
    logic consume;
    logic consume_last;

    assign up.row_ready  = ~pend_full & ~flush & ~rst;
    assign accept        = up.row_valid & up.row_ready;
    assign consume       = pixel_en & act_full;
    assign consume_last  = consume & (act_cnt == CNT_LAST);

    assign pixel_valid = act_full;
    assign pixel_out   = act_full ? act_row[ROW_W-1 -: PIXEL_BITS] : '0;
    assign pixel_attr  = act_full ? act_attr : 3'd0;
    assign pixel_last  = act_full & (act_cnt == CNT_LAST);
    assign underrun    = underrun_q;

    // Next-state for both row buffers: flush wins, then consume, then an accepted row fills
    // whichever buffer is free (active directly when it is empty or just emptied).
    always_comb begin
        act_row_n   = act_row;
        act_attr_n  = act_attr;
        act_cnt_n   = act_cnt;
        act_full_n  = act_full;
        pend_row_n  = pend_row;
        pend_attr_n = pend_attr;
        pend_full_n = pend_full;
        underrun_n  = underrun_q;

        if (flush) begin
            act_full_n  = 1'b0;
            pend_full_n = 1'b0;
            act_cnt_n   = '0;
        end else begin
            if (pixel_en && !act_full) begin
                underrun_n = 1'b1;
            end

            if (consume) begin
                if (!consume_last) begin
                    act_row_n = act_row << PIXEL_BITS;
                    act_cnt_n = act_cnt + 1'b1;
                end else if (pend_full) begin
                    act_row_n   = pend_row;
                    act_attr_n  = pend_attr;
                    act_cnt_n   = '0;
                    pend_full_n = 1'b0;
                end else begin
                    act_full_n = 1'b0;
                    act_cnt_n  = '0;
                end
            end

            // accept implies pend_full == 0, so a last-pixel consume never competes with it here
            if (accept) begin
                if (!act_full || consume_last) begin
                    act_row_n  = up.row_in;
                    act_attr_n = up.row_attr;
                    act_cnt_n  = '0;
                    act_full_n = 1'b1;
                end else begin
                    pend_row_n  = up.row_in;
                    pend_attr_n = up.row_attr;
                    pend_full_n = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset discarding both rows and the underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_row    <= '0;
            act_attr   <= '0;
            act_cnt    <= '0;
            act_full   <= 1'b0;
            pend_row   <= '0;
            pend_attr  <= '0;
            pend_full  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            act_row    <= act_row_n;
            act_attr   <= act_attr_n;
            act_cnt    <= act_cnt_n;
            act_full   <= act_full_n;
            pend_row   <= pend_row_n;
            pend_attr  <= pend_attr_n;
            pend_full  <= pend_full_n;
            underrun_q <= underrun_n;
        end
    end
endmodule

// File: tb/tb_pattern_row_serializer_m.sv
// Bench for the pattern row serializer: directed scenarios plus random traffic, all checked
// against a queue-of-rows reference model.
module tb_pattern_row_serializer_m;
    logic       clk;
    logic       rst;
    logic       flush;
    logic       pixel_en;
    logic [1:0] pixel_out;
    logic [2:0] pixel_attr;
    logic       pixel_valid;
    logic       pixel_last;
    logic       underrun;

    pattern_row_serializer_m_if bus ();

    pattern_row_serializer_m dut (
        .clk        (clk),
        .rst        (rst),
        .up         (bus.slave),
        .flush      (flush),
        .pixel_en   (pixel_en),
        .pixel_out  (pixel_out),
        .pixel_attr (pixel_attr),
        .pixel_valid(pixel_valid),
        .pixel_last (pixel_last),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of buffered rows (head is the one shifting) and pixel index in head
    logic [15:0] q_row[$];
    logic [2:0]  q_attr[$];
    int          m_idx = 0;
    bit          m_underrun = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [15:0] head;
        int          sz;
        int          e_pix;
        sz = q_row.size();
        e_pix = 0;
        if (sz > 0) begin
            head  = q_row[0];
            e_pix = int'((head >> (14 - 2 * m_idx)) & 16'h3);
        end
        chk("valid", {31'd0, pixel_valid}, (sz > 0) ? 1 : 0);
        chk("pix",   {30'd0, pixel_out},   e_pix);
        chk("attr",  {29'd0, pixel_attr},  (sz > 0) ? {29'd0, q_attr[0]} : 0);
        chk("last",  {31'd0, pixel_last},  (sz > 0 && m_idx == 7) ? 1 : 0);
        chk("under", {31'd0, underrun},    {31'd0, m_underrun});
        chk("ready", {31'd0, bus.row_ready}, (sz < 2 && !flush && !rst) ? 1 : 0);
    endtask

    task automatic model_update();
        bit acc;
        if (rst) begin
            q_row.delete(); q_attr.delete(); m_idx = 0; m_underrun = 0;
        end else if (flush) begin
            q_row.delete(); q_attr.delete(); m_idx = 0;
        end else begin
            acc = bus.row_valid && (q_row.size() < 2);
            if (pixel_en) begin
                if (q_row.size() == 0) m_underrun = 1;
                else begin
                    m_idx++;
                    if (m_idx == 8) begin
                        void'(q_row.pop_front()); void'(q_attr.pop_front()); m_idx = 0;
                    end
                end
            end
            if (acc) begin
                q_row.push_back(bus.row_in); q_attr.push_back(bus.row_attr);
            end
        end
    endtask

    // Apply inputs just after an edge, then compare everything against the model
    task automatic drive(input bit rv, input logic [15:0] r, input logic [2:0] a,
                         input bit fl, input bit pe, input bit rs);
        bus.row_valid = rv; bus.row_in = r; bus.row_attr = a;
        flush = fl; pixel_en = pe; rst = rs;
        #1;
        check_model();
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 16'h0, 3'd0, 0, 0, 1);
        clk_edge();
    endtask

    initial begin
        int exp_t1[8];
        logic [15:0] t2r[3];
        int i, cyc, vcount, falls;
        bit prev_v;
        exp_t1 = '{3, 2, 1, 0, 3, 2, 1, 0};
        t2r    = '{16'hFFFF, 16'h0000, 16'h5555};

        bus.row_valid = 0; bus.row_in = 0; bus.row_attr = 0;
        flush = 0; pixel_en = 0; rst = 1;
        @(posedge clk);
        model_update();
        #1;

        // T1: single row, one pixel per cycle
        do_reset();
        drive(1, 16'hE4E4, 3'd5, 0, 0, 0);
        clk_edge();
        for (int k = 0; k < 8; k++) begin
            drive(0, 16'h0, 3'd0, 0, 1, 0);
            chk("t1_pix",  {30'd0, pixel_out}, exp_t1[k]);
            chk("t1_attr", {29'd0, pixel_attr}, 5);
            chk("t1_last", {31'd0, pixel_last}, (k == 7) ? 1 : 0);
            clk_edge();
        end
        drive(0, 16'h0, 3'd0, 0, 0, 0);
        chk("t1_drop", {31'd0, pixel_valid}, 0);
        clk_edge();

        // T2: three rows back-to-back, expect 24 contiguous valid pixels
        do_reset();
        i = 0; cyc = 0; vcount = 0; falls = 0; prev_v = 0;
        while ((i < 3 || q_row.size() > 0) && cyc < 60) begin
            drive(i < 3, (i < 3) ? t2r[i] : 16'h0, 3'd2, 0, q_row.size() > 0, 0);
            if (pixel_valid) vcount++;
            if (prev_v && !pixel_valid) falls++;
            prev_v = pixel_valid;
            if (i < 3 && q_row.size() < 2) i++;
            clk_edge();
            cyc++;
        end
        chk("t2_timeout", (cyc < 60) ? 1 : 0, 1);
        chk("t2_count", vcount, 24);
        chk("t2_gap", falls, 0);

        // T3: pixel_en every other cycle
        do_reset();
        drive(1, 16'h1B1B, 3'd1, 0, 0, 0);
        clk_edge();
        for (int k = 0; k < 16; k++) begin
            drive(0, 16'h0, 3'd0, 0, k[0], 0);
            chk("t3_pix", {30'd0, pixel_out}, (k / 2) % 4);
            clk_edge();
        end

        // T4: underrun with no row, sticky across later rows
        do_reset();
        drive(0, 16'h0, 3'd0, 0, 1, 0);
        chk("t4_pre", {31'd0, underrun}, 0);
        clk_edge();
        drive(1, 16'hA5A5, 3'd4, 0, 0, 0);
        chk("t4_under", {31'd0, underrun}, 1);
        chk("t4_pix0",  {30'd0, pixel_out}, 0);
        clk_edge();
        for (int k = 0; k < 9; k++) begin
            drive(0, 16'h0, 3'd0, 0, 1, 0);
            clk_edge();
        end
        drive(0, 16'h0, 3'd0, 0, 0, 0);
        chk("t4_sticky", {31'd0, underrun}, 1);
        clk_edge();

        // T5: flush after 3 pixels with pending full
        do_reset();
        drive(1, 16'h1234, 3'd1, 0, 0, 0); clk_edge();
        drive(1, 16'h5678, 3'd2, 0, 0, 0); clk_edge();
        for (int k = 0; k < 3; k++) begin
            drive(0, 16'h0, 3'd0, 0, 1, 0); clk_edge();
        end
        drive(1, 16'hFFFF, 3'd7, 1, 1, 0);
        chk("t5_ready", {31'd0, bus.row_ready}, 0);
        clk_edge();
        drive(0, 16'h0, 3'd0, 0, 0, 0);
        chk("t5_valid", {31'd0, pixel_valid}, 0);
        clk_edge();
        drive(1, 16'hC000, 3'd6, 0, 0, 0); clk_edge();
        drive(0, 16'h0, 3'd0, 0, 0, 0);
        chk("t5_pix",  {30'd0, pixel_out}, 3);
        chk("t5_attr", {29'd0, pixel_attr}, 6);
        clk_edge();

        // T6: reset mid-row
        do_reset();
        drive(1, 16'hE4E4, 3'd3, 0, 0, 0); clk_edge();
        for (int k = 0; k < 4; k++) begin
            drive(1, 16'h9999, 3'd2, 0, 1, 0); clk_edge();
        end
        drive(1, 16'h9999, 3'd2, 0, 0, 1);
        chk("t6_ready_rst", {31'd0, bus.row_ready}, 0);
        clk_edge();
        drive(0, 16'h0, 3'd0, 0, 0, 1);
        chk("t6_valid", {31'd0, pixel_valid}, 0);
        chk("t6_pix",   {30'd0, pixel_out}, 0);
        chk("t6_under", {31'd0, underrun}, 0);
        clk_edge();
        drive(0, 16'h0, 3'd0, 0, 0, 0);
        chk("t6_ready_after", {31'd0, bus.row_ready}, 1);
        clk_edge();

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 1), 16'($urandom), 3'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0);
            clk_edge();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
